// File: rtl/synaptic_proc_unit_pkg.sv
// Shared widths and one-hot state encoding for the synaptic processing unit.
package synaptic_proc_unit_pkg;

    localparam int SPU_DATA_W = 17;
    localparam int SPU_TAG_W  = 1;

    typedef enum logic [4:0] {
        ST_WAIT  = 5'b00001,
        ST_DEQ   = 5'b00010,
        ST_FETCH = 5'b00100,
        ST_ADD   = 5'b01000,
        ST_WB    = 5'b10000
    } spu_state_e;

endpackage

// File: rtl/synaptic_proc_unit_sat_adder.sv
// Two's-complement adder that clamps to the most positive / most negative word on overflow.
module spu_sat_adder #(
    parameter int DATA_W = 17
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] raw;
    logic              ovf;

    assign raw = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    assign ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);

    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/synaptic_proc_unit.sv
// Dequeues a spike source tag and accumulates weight[src][dst] into i_next[dst] for every dst.
module synaptic_proc_unit
    import synaptic_proc_unit_pkg::*;
#(
    parameter int DATA_W = SPU_DATA_W,
    parameter int TAG_W  = SPU_TAG_W
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] weight_in,
    input  logic [DATA_W-1:0] i_next_in,
    input  logic [TAG_W-1:0]  src_tag_in,
    output logic [4:0]        state,
    output logic              req_write_i_next,
    output logic              req_deq,
    output logic              busy,
    output logic [DATA_W-1:0] i_next_out,
    output logic [TAG_W-1:0]  src_tag_out,
    output logic [TAG_W-1:0]  dst_tag_out
);

    localparam logic [TAG_W-1:0] LAST_TAG = {TAG_W{1'b1}};

    spu_state_e        st;
    logic [DATA_W-1:0] weight_q;
    logic [DATA_W-1:0] i_next_q;
    logic [DATA_W-1:0] sum;

    spu_sat_adder #(.DATA_W(DATA_W)) u_add (
        .a   (weight_q),
        .b   (i_next_q),
        .sum (sum)
    );

    assign state = st;
    assign busy  = (st != ST_WAIT);

    // Strobes are set on the transition into their state so they are registered Moore outputs.
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            st               <= ST_WAIT;
            req_deq          <= 1'b0;
            req_write_i_next <= 1'b0;
            i_next_out       <= '0;
            src_tag_out      <= '0;
            dst_tag_out      <= '0;
            weight_q         <= '0;
            i_next_q         <= '0;
        end else begin
            req_deq          <= 1'b0;
            req_write_i_next <= 1'b0;
            case (st)
                ST_WAIT: begin
                    dst_tag_out <= '0;
                    if (!fifo_empty) begin
                        st      <= ST_DEQ;
                        req_deq <= 1'b1;
                    end
                end
                ST_DEQ: begin
                    src_tag_out <= src_tag_in;
                    st          <= ST_FETCH;
                end
                ST_FETCH: begin
                    weight_q <= weight_in;
                    i_next_q <= i_next_in;
                    st       <= ST_ADD;
                end
                ST_ADD: begin
                    i_next_out       <= sum;
                    req_write_i_next <= 1'b1;
                    st               <= ST_WB;
                end
                ST_WB: begin
                    if (dst_tag_out == LAST_TAG) begin
                        dst_tag_out <= '0;
                        st          <= ST_WAIT;
                    end else begin
                        dst_tag_out <= dst_tag_out + 1'b1;
                        st          <= ST_FETCH;
                    end
                end
                default: st <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_synaptic_proc_unit.sv
// Directed bench for synaptic_proc_unit with hand-computed expected values.
module tb_synaptic_proc_unit;

    logic        clk = 1'b0;
    logic        asyn_reset;
    logic        fifo_empty;
    logic [16:0] weight_in;
    logic [16:0] i_next_in;
    logic [0:0]  src_tag_in;
    logic [4:0]  state;
    logic        req_write_i_next;
    logic        req_deq;
    logic        busy;
    logic [16:0] i_next_out;
    logic [0:0]  src_tag_out;
    logic [0:0]  dst_tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] S_WAIT  = 5'b00001;
    localparam logic [4:0] S_DEQ   = 5'b00010;
    localparam logic [4:0] S_FETCH = 5'b00100;
    localparam logic [4:0] S_ADD   = 5'b01000;
    localparam logic [4:0] S_WB    = 5'b10000;

    synaptic_proc_unit #(.DATA_W(17), .TAG_W(1)) dut (
        .clk              (clk),
        .asyn_reset       (asyn_reset),
        .fifo_empty       (fifo_empty),
        .weight_in        (weight_in),
        .i_next_in        (i_next_in),
        .src_tag_in       (src_tag_in),
        .state            (state),
        .req_write_i_next (req_write_i_next),
        .req_deq          (req_deq),
        .busy             (busy),
        .i_next_out       (i_next_out),
        .src_tag_out      (src_tag_out),
        .dst_tag_out      (dst_tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full spike: two destinations, each with its own operands and expected sum.
    task automatic run_spike(input logic [0:0] src,
                             input logic [16:0] w0, input logic [16:0] i0, input logic [16:0] e0,
                             input logic [16:0] w1, input logic [16:0] i1, input logic [16:0] e1);
        fifo_empty = 1'b0;
        src_tag_in = src;
        weight_in  = w0;
        i_next_in  = i0;
        step();
        chk("deq_state", 32'(state), 32'(S_DEQ));
        chk("deq_strobe", 32'(req_deq), 32'd1);
        chk("deq_busy", 32'(busy), 32'd1);
        fifo_empty = 1'b1;
        step();
        src_tag_in = ~src;
        chk("fetch0_state", 32'(state), 32'(S_FETCH));
        chk("src_latched", 32'(src_tag_out), 32'(src));
        chk("fetch0_dst", 32'(dst_tag_out), 32'd0);
        chk("fetch0_deq_low", 32'(req_deq), 32'd0);
        step();
        chk("add0_state", 32'(state), 32'(S_ADD));
        chk("add0_wr_low", 32'(req_write_i_next), 32'd0);
        step();
        chk("wb0_state", 32'(state), 32'(S_WB));
        chk("wb0_sum", 32'(i_next_out), 32'(e0));
        chk("wb0_wr", 32'(req_write_i_next), 32'd1);
        weight_in = w1;
        i_next_in = i1;
        step();
        chk("fetch1_state", 32'(state), 32'(S_FETCH));
        chk("fetch1_dst", 32'(dst_tag_out), 32'd1);
        chk("fetch1_wr_low", 32'(req_write_i_next), 32'd0);
        step();
        step();
        chk("wb1_state", 32'(state), 32'(S_WB));
        chk("wb1_sum", 32'(i_next_out), 32'(e1));
        chk("wb1_wr", 32'(req_write_i_next), 32'd1);
        chk("wb1_dst", 32'(dst_tag_out), 32'd1);
        step();
        chk("end_state", 32'(state), 32'(S_WAIT));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_dst", 32'(dst_tag_out), 32'd0);
        chk("end_hold_sum", 32'(i_next_out), 32'(e1));
        chk("end_hold_src", 32'(src_tag_out), 32'(src));
    endtask

    initial begin
        asyn_reset = 1'b0;
        fifo_empty = 1'b0;
        weight_in  = 17'h0;
        i_next_in  = 17'h0;
        src_tag_in = 1'b1;
        step();
        step();
        chk("rst_state", 32'(state), 32'(S_WAIT));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_deq", 32'(req_deq), 32'd0);
        chk("rst_wr", 32'(req_write_i_next), 32'd0);
        chk("rst_sum", 32'(i_next_out), 32'd0);
        chk("rst_src", 32'(src_tag_out), 32'd0);
        chk("rst_dst", 32'(dst_tag_out), 32'd0);

        fifo_empty = 1'b1;
        asyn_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_state", 32'(state), 32'(S_WAIT));
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_deq", 32'(req_deq), 32'd0);
            chk("idle_wr", 32'(req_write_i_next), 32'd0);
        end

        run_spike(1'b1, 17'h00800, 17'h00100, 17'h00900,
                        17'h01000, 17'h00101, 17'h01101);
        run_spike(1'b0, 17'h0FFFF, 17'h00001, 17'h0FFFF,
                        17'h10000, 17'h1FFFF, 17'h10000);
        // Mixed-sign and small negative sums stay unclamped.
        run_spike(1'b1, 17'h1FFFE, 17'h00005, 17'h00003,
                        17'h1FFF0, 17'h1FFF0, 17'h1FFE0);

        // Back-to-back spikes: one WAIT cycle after WB before the next DEQ.
        fifo_empty = 1'b0;
        src_tag_in = 1'b0;
        step();
        chk("b2b_deq", 32'(state), 32'(S_DEQ));

        // Abort in ADD with an asynchronous reset.
        fifo_empty = 1'b1;
        weight_in  = 17'h00001;
        i_next_in  = 17'h00001;
        step();
        step();
        chk("abort_in_add", 32'(state), 32'(S_ADD));
        asyn_reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'(S_WAIT));
        chk("abort_wr", 32'(req_write_i_next), 32'd0);
        chk("abort_sum", 32'(i_next_out), 32'd0);
        fifo_empty = 1'b0;
        step();
        chk("abort_hold_wr", 32'(req_write_i_next), 32'd0);
        chk("abort_hold_deq", 32'(req_deq), 32'd0);
        chk("abort_hold_state", 32'(state), 32'(S_WAIT));
        asyn_reset = 1'b1;
        step();
        chk("fresh_deq_state", 32'(state), 32'(S_DEQ));
        chk("fresh_deq_strobe", 32'(req_deq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
